// File: rtl/clock_divisor_prog.sv
// rtl/clock_divisor_prog.sv - programmable clock divider with shadowed period/duty, toggle/PWM output and wrap tick
module clock_divisor_prog #(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned DEFAULT_N = 12500000,
  parameter int unsigned DEFAULT_D = 6250000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] div_n,
  input  logic [WIDTH-1:0] div_d,
  output logic             clock_Salida,
  output logic             tick,
  output logic             pending
);

  localparam logic [WIDTH-1:0] DEF_N = WIDTH'(DEFAULT_N);
  localparam logic [WIDTH-1:0] DEF_D = WIDTH'(DEFAULT_D);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] active_n_q, active_n_d;
  logic [WIDTH-1:0] active_d_q, active_d_d;
  logic [WIDTH-1:0] shadow_n_q, shadow_n_d;
  logic [WIDTH-1:0] shadow_d_q, shadow_d_d;
  logic             pending_q, pending_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             wrap;

  // A wrap ends the current period; it is the only point where new values are applied.
  assign wrap = enable && (cnt_q == active_n_q);

  // Next-state: counting, boundary apply, output shaping and shadow capture.
  always_comb begin
    cnt_d      = cnt_q;
    active_n_d = active_n_q;
    active_d_d = active_d_q;
    shadow_n_d = shadow_n_q;
    shadow_d_d = shadow_d_q;
    pending_d  = pending_q;
    out_d      = out_q;
    tick_d     = 1'b0;

    if (enable) begin
      if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        if (pending_q) begin
          active_n_d = shadow_n_q;
          active_d_d = shadow_d_q;
          pending_d  = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
      // PWM compares the count this edge produces against the duty in force for it.
      if (!mode) begin
        if (wrap) out_d = ~out_q;
      end else begin
        out_d = (cnt_d < active_d_d);
      end
    end else if (pending_q && !load) begin
      // While stopped there is no period to protect, so apply at once and restart the period.
      active_n_d = shadow_n_q;
      active_d_d = shadow_d_q;
      pending_d  = 1'b0;
      cnt_d      = '0;
    end

    // A load always lands in the shadow and wins over a same-cycle apply of the old shadow.
    if (load) begin
      shadow_n_d = div_n;
      shadow_d_d = div_d;
      pending_d  = 1'b1;
    end
  end

  // State registers; reset overrides everything, including an in-flight load.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= '0;
      active_n_q <= DEF_N;
      active_d_q <= DEF_D;
      shadow_n_q <= DEF_N;
      shadow_d_q <= DEF_D;
      pending_q  <= 1'b0;
      out_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      active_n_q <= active_n_d;
      active_d_q <= active_d_d;
      shadow_n_q <= shadow_n_d;
      shadow_d_q <= shadow_d_d;
      pending_q  <= pending_d;
      out_q      <= out_d;
      tick_q     <= tick_d;
    end
  end

  assign clock_Salida = out_q;
  assign tick         = tick_q;
  assign pending      = pending_q;

endmodule
